// File: rtl/ctrl_conv_input_if.sv
// rtl/ctrl_conv_input_if.sv - stream, memory-write and start/done signals of the conv input controller
interface ctrl_conv_input_if #(
    parameter int T = 20
);
    logic [T-1:0] s_data_in_x;
    logic         s_valid_x;
    logic         s_ready_x;
    logic [T-1:0] s_data_in_f;
    logic         s_valid_f;
    logic         s_ready_f;
    logic         xmem_wr_en;
    logic [4:0]   xmem_addr;
    logic [T-1:0] xmem_data;
    logic         fmem_wr_en;
    logic [3:0]   fmem_addr;
    logic [T-1:0] fmem_data;
    logic         conv_start;
    logic         conv_done;

    modport slave (
        input  s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, conv_done,
        output s_ready_x, s_ready_f, xmem_wr_en, xmem_addr, xmem_data,
               fmem_wr_en, fmem_addr, fmem_data, conv_start
    );

    modport master (
        output s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, conv_done,
        input  s_ready_x, s_ready_f, xmem_wr_en, xmem_addr, xmem_data,
               fmem_wr_en, fmem_addr, fmem_data, conv_start
    );
endinterface

// File: rtl/ctrl_conv_input.sv
// rtl/ctrl_conv_input.sv - loads x/f memories from two streams, then holds conv_start until conv_done
// Optional WEIGHT_REUSE_EN: coefficients persist across batches and only x is reloaded.
module ctrl_conv_input #(
    parameter int N = 20,
    parameter int M = 13,
    parameter int T = 20
) (
    input  logic              clk,
    input  logic              reset,
    ctrl_conv_input_if.slave  bus
);
    typedef enum logic {LOAD, RUN} state_t;

    localparam logic [4:0] X_LAST = 5'(N - 1);
    localparam logic [3:0] F_LAST = 4'(M - 1);

    state_t       state, state_next;
    logic [4:0]   x_cnt;
    logic [3:0]   f_cnt;
    logic         x_full, f_full;
    logic         ready_x, ready_f, start, batch_done;
    logic         x_hs, f_hs;
    logic [T-1:0] x_data, f_data;

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready_x    = 1'b0;
        ready_f    = 1'b0;
        start      = 1'b0;
        batch_done = 1'b0;
        case (state)
            LOAD: begin
                ready_x = !x_full;
                ready_f = !f_full;
                if (x_full && f_full) state_next = RUN;
            end
            RUN: begin
                start = 1'b1;
                if (bus.conv_done) begin
                    state_next = LOAD;
                    batch_done = 1'b1;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    assign x_hs = bus.s_valid_x & ready_x;
    assign f_hs = bus.s_valid_f & ready_f;

    // Counters saturate at the last address; the full flag closes the stream instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt  <= '0;
            x_full <= 1'b0;
            f_cnt  <= '0;
            f_full <= 1'b0;
        end else if (batch_done) begin
            x_cnt  <= '0;
            x_full <= 1'b0;
`ifdef WEIGHT_REUSE_EN
            // coefficients stay loaded; only reset reopens the f stream
`else
            f_cnt  <= '0;
            f_full <= 1'b0;
`endif
        end else begin
            if (x_hs) begin
                if (x_cnt == X_LAST) x_full <= 1'b1;
                else                 x_cnt  <= x_cnt + 5'd1;
            end
            if (f_hs) begin
                if (f_cnt == F_LAST) f_full <= 1'b1;
                else                 f_cnt  <= f_cnt + 4'd1;
            end
        end
    end

    assign x_data         = bus.s_data_in_x;
    assign f_data         = bus.s_data_in_f;

    assign bus.s_ready_x  = ready_x;
    assign bus.s_ready_f  = ready_f;
    assign bus.conv_start = start;
    assign bus.xmem_wr_en = x_hs;
    assign bus.xmem_addr  = x_cnt;
    assign bus.xmem_data  = x_data;
    assign bus.fmem_wr_en = f_hs;
    assign bus.fmem_addr  = f_cnt;
    assign bus.fmem_data  = f_data;
endmodule
